mul_sequencer: RTL

Multi-cycle sequencer for the MIPS `mul` instruction. It computes the low 32 bits of a 32x32 product by shift-and-add. Each accumulate step is issued to the shared `alu` instance as an `ALU_ADDU` or `ALU_PASSX` operation. It sits beside the execute stage, drives the ALU operand/opcode muxes while `busy` is high, and signals the pipeline to stall until `done`.

---
 rtl/mul_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Multi-cycle sequencer for the MIPS `mul` instruction. Produces the low 32
// bits of op_x*op_y by shift-and-add, borrowing the execute stage's shared ALU
// for every accumulate step (ADDU when the current multiplier bit is set,
// PASSX otherwise). While busy is high the pipeline stalls and the ALU operand
// and opcode muxes select this block's drive.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous active-high reset, dominates everything
//   start       in   1   request, honoured only in IDLE or DONE
//   kill        in   1   abort the in-flight operation (pipeline flush)
//   op_x        in  32   multiplicand, captured on an accepted start
//   op_y        in  32   multiplier, captured on an accepted start
//   busy        out  1   high while iterating
//   done        out  1   one-cycle pulse, result valid
//   result      out 32   low word of the product, held until the next result
//   alu_opcode  out  4   opcode to the shared ALU
//   alu_op_x    out 32   ALU operand X (accumulator)
//   alu_op_y    out 32   ALU operand Y (shifted multiplicand)
//   alu_result  in  32   ALU output, consumed in the same cycle
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int MAX_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] op_x,
  input  logic [31:0] op_y,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  alu_opcode,
  output logic [31:0] alu_op_x,
  output logic [31:0] alu_op_y,
  input  logic [31:0] alu_result
);

  // Opcode encodings; keep in step with the ALU decode in mips_defines.v.
  localparam logic [3:0] ALU_ADDU  = 4'h1;
  localparam logic [3:0] ALU_PASSX = 4'hA;

  localparam logic [4:0] LAST_COUNT = 5'(MAX_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  count;

  // Early-out once no set multiplier bits remain above the one consumed now.
  logic last_step;
  assign last_step = (mplier[31:1] == 31'd0) || (count == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      count  <= 5'd0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // Flush: drop the operation silently, result keeps its old value.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              mcand  <= op_x;
              mplier <= op_y;
              acc    <= 32'd0;
              count  <= 5'd0;
              state  <= RUN;
              busy   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          RUN: begin
            acc    <= alu_result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (last_step) begin
              // The final accumulate is on the ALU output this cycle, so the
              // result register is loaded straight from it.
              result <= alu_result;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // ALU drive is a pure mux of registered state: no extra stage sits between
  // this block and the ALU, and the ALU sees neutral operands outside RUN.
  always_comb begin
    alu_opcode = ALU_PASSX;
    alu_op_x   = 32'd0;
    alu_op_y   = 32'd0;
    if (state == RUN) begin
      alu_op_x = acc;
      alu_op_y = mcand;
      if (mplier[0]) alu_opcode = ALU_ADDU;
    end
  end

endmodule
